// File: rtl/burst_mem_responder.sv
// Line-burst memory endpoint: single-pulse reads return four 64-bit beats after
// READ_LATENCY cycles; four back-to-back write beats commit one 256-bit line.
module burst_mem_responder #(
    parameter int LINES        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dfp_addr,
    input  logic        dfp_read,
    input  logic        dfp_write,
    input  logic [63:0] dfp_wdata,
    output logic [63:0] dfp_rdata,
    output logic        dfp_resp,
    output logic        proto_err
);
    localparam int         IDX_W    = $clog2(LINES);
    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_READ_BURST,
        S_WRITE_BURST,
        S_WRITE_RESP
    } state_t;

    logic [255:0]     r_mem [LINES];
    logic [191:0]     r_wbuf;
    state_t           r_state;
    logic [IDX_W-1:0] r_line;
    logic [3:0]       r_cnt;
    logic [1:0]       r_beat;
    logic [63:0]      r_rdata;
    logic             r_resp;
    logic             r_proto_err;

    state_t           w_state_next;
    logic [IDX_W-1:0] w_line_next;
    logic [3:0]       w_cnt_next;
    logic [1:0]       w_beat_next;
    logic             w_err_set;
    logic             w_buf_we;
    logic             w_commit;
    logic [1:0]       w_wr_slot;
    logic [IDX_W-1:0] w_addr_idx;
    logic [255:0]     w_rd_line;
    logic [63:0]      w_rdata_next;
    logic             w_resp_next;
    logic             w_unused_addr;

    assign w_addr_idx    = dfp_addr[5 +: IDX_W];
    assign w_unused_addr = ^{dfp_addr[31:5+IDX_W], dfp_addr[4:0]};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_line_next  = r_line;
        w_cnt_next   = r_cnt;
        w_beat_next  = r_beat;
        w_err_set    = 1'b0;
        w_buf_we     = 1'b0;
        w_commit     = 1'b0;

        case (r_state)
            S_IDLE, S_WRITE_RESP: begin
                w_state_next = S_IDLE;
                if (dfp_read && dfp_write) begin
                    w_err_set = 1'b1;
                end else if (dfp_read) begin
                    w_line_next = w_addr_idx;
                    w_beat_next = 2'd0;
                    if (READ_LATENCY == 1) begin
                        w_state_next = S_READ_BURST;
                    end else begin
                        w_state_next = S_READ_WAIT;
                        w_cnt_next   = LAT_LOAD;
                    end
                end else if (dfp_write) begin
                    w_line_next  = w_addr_idx;
                    w_buf_we     = 1'b1;
                    w_beat_next  = 2'd1;
                    w_state_next = S_WRITE_BURST;
                end
            end

            S_READ_WAIT: begin
                w_err_set  = dfp_read || dfp_write;
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = S_READ_BURST;
                    w_beat_next  = 2'd0;
                end
            end

            S_READ_BURST: begin
                w_err_set = dfp_read || dfp_write;
                if (r_beat == 2'd3) begin
                    w_state_next = S_IDLE;
                    w_beat_next  = 2'd0;
                end else begin
                    w_beat_next = r_beat + 2'd1;
                end
            end

            S_WRITE_BURST: begin
                w_err_set = dfp_read;
                if (dfp_write) begin
                    w_buf_we = 1'b1;
                    if (r_beat == 2'd3) begin
                        w_commit     = 1'b1;
                        w_state_next = S_WRITE_RESP;
                        w_beat_next  = 2'd0;
                    end else begin
                        w_beat_next = r_beat + 2'd1;
                    end
                end else begin
                    // A gap in the beat stream abandons the whole line.
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                    w_beat_next  = 2'd0;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_beat_next  = 2'd0;
            end
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        w_rd_line    = r_mem[w_line_next];
        w_resp_next  = (w_state_next == S_READ_BURST) || (w_state_next == S_WRITE_RESP);
        w_rdata_next = '0;
        if (w_state_next == S_READ_BURST) begin
            w_rdata_next = w_rd_line[{w_beat_next, 6'd0} +: 64];
        end
    end

    assign w_wr_slot = (r_state == S_WRITE_BURST) ? r_beat : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_line      <= '0;
            r_cnt       <= '0;
            r_beat      <= '0;
            r_rdata     <= '0;
            r_resp      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_line  <= w_line_next;
            r_cnt   <= w_cnt_next;
            r_beat  <= w_beat_next;
            r_rdata <= w_rdata_next;
            r_resp  <= w_resp_next;
            if (w_err_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // NOTE: storage and the write staging buffer have no reset so they map onto RAM.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            case (w_wr_slot)
                2'd0:    r_wbuf[63:0]    <= dfp_wdata;
                2'd1:    r_wbuf[127:64]  <= dfp_wdata;
                2'd2:    r_wbuf[191:128] <= dfp_wdata;
                default: ;
            endcase
        end
        if (w_commit) begin
            r_mem[r_line] <= {dfp_wdata, r_wbuf};
        end
    end

    assign dfp_rdata = r_rdata;
    assign dfp_resp  = r_resp;
    assign proto_err = r_proto_err;

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the 64-bit, 4-beat line-burst interface driven by the cacheline adaptor.
- Holds a line-addressed storage array of 256-bit lines.
- Accepts single-cycle read requests and returns four consecutive 64-bit beats after a fixed latency.
- Accepts four back-to-back write beats and commits them as one line.
- Serves as the synthesizable main-memory endpoint for cache bring-up, and as the checking model for the adaptor's burst timing.

Parameters:
- LINES, 256: number of 256-bit lines stored; must be a power of two.
- READ_LATENCY, 2: cycles from the sampled read request to the first read beat; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dfp_addr  input  32  byte address; bits [4:0] are ignored; line index = dfp_addr[5 +: log2(LINES)]; upper bits are ignored (aliasing).
- dfp_read  input  1  read request; one-cycle pulse.
- dfp_write  input  1  write beat valid; high for 4 consecutive cycles per burst.
- dfp_wdata  input  64  write beat data; beat 0 is line bits [63:0], beat 3 is line bits [255:192].
- dfp_rdata  output  64  read beat data; registered.
- dfp_resp  output  1  high on each read beat; one-cycle pulse after a write burst; registered.
- proto_err  output  1  sticky protocol-violation flag; cleared only by rst.

Behaviour:
- Reset (async assert): state IDLE; dfp_rdata=0, dfp_resp=0, proto_err=0; beat counter and latency counter cleared; any partial write is discarded. Array contents are not reset.
- State IDLE (also accepts requests in WRITE_RESP):
  - dfp_read && !dfp_write: latch the line index; go to READ_WAIT with latency count = READ_LATENCY-1. If READ_LATENCY=1, go directly to READ_BURST.
  - dfp_write && !dfp_read: latch the line index; store dfp_wdata as beat 0; go to WRITE_BURST with beat=1.
  - dfp_read && dfp_write: set proto_err; ignore both; stay in IDLE.
- READ_WAIT: decrement the count; at 0 go to READ_BURST with beat=0.
- READ_BURST: four consecutive cycles.
  - dfp_resp=1, dfp_rdata = line[64*beat +: 64], beat 0..3.
  - After beat 3, return to IDLE; dfp_resp and dfp_rdata are 0 the next cycle.
  - Timing: a request sampled at edge T produces its first beat in the cycle following edge T+READ_LATENCY-1, i.e. dfp_resp is visible READ_LATENCY cycles after the request cycle.
- WRITE_BURST: expects dfp_write=1 on each of the 3 following cycles.
  - Store beats 1..3; dfp_addr is not re-sampled.
  - After beat 3 is sampled, commit the full line to the array on that edge, then go to WRITE_RESP.
  - If dfp_write=0 in any of these cycles: set proto_err, discard the burst, return to IDLE; nothing is committed.
- WRITE_RESP: one cycle with dfp_resp=1, dfp_rdata=0. Requests sampled in this cycle are handled exactly as in IDLE.
- Requests during READ_WAIT/READ_BURST: set proto_err and are ignored; the in-flight burst completes unaffected.
  - Exception: dfp_write inside WRITE_BURST is the expected beat.
  - dfp_read inside WRITE_BURST: set proto_err, read ignored, write continues.
- Ordering: a read sampled after a write's commit edge returns the new data (read-after-write coherent). The array is read at the start of READ_BURST, not at request time.
- dfp_rdata is 0 whenever dfp_resp is 0.
- Reset asserted mid-burst: immediate return to IDLE; outputs go to 0 asynchronously; no further beats.

Test Plan:
- Write line 0x40: 4 beats 0x1111..1111, 0x2222..2222, 0x3333..3333, 0x4444..4444 -> dfp_resp pulses 1 cycle after the 4th beat; proto_err=0.
- Read 0x40 with READ_LATENCY=2 (request at cycle 10) -> dfp_resp high cycles 12-15; dfp_rdata = 0x1111.., 0x2222.., 0x3333.., 0x4444.. in order; cycle 16 resp=0, rdata=0.
- Address aliasing with LINES=256: write 0x0000_2040 (index 2, since 0x2040 = 0b10_0000_0100_0000, bits[12:5]=0b0000_0010), then read 0x0000_0040 (index 2) -> returns the written data. Read 0x0000_0050 (bits[4:0] ignored) -> same data.
- Broken write: write beats 0,1 then dfp_write=0 -> proto_err=1, no resp; a subsequent read of that line returns the prior contents.
- Overlap: dfp_read issued during READ_BURST, or dfp_read && dfp_write in IDLE -> proto_err=1; the current burst still delivers 4 correct beats.
- Async rst asserted during READ_BURST beat 1 -> dfp_resp=0 and dfp_rdata=0 immediately. After release, a new read of the same line returns full correct data.
